// File: rtl/dac_spi_tx.sv
// Serial DAC driver: samples wave_data every SAMPLE_DIV clocks and shifts it out
// MSB first as a 16-bit SPI word {CTRL_BITS, wave_data, 4'b0000}.
module dac_spi_tx #(
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 500,
  parameter logic [3:0] CTRL_BITS  = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] wave_data,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  localparam int            TW        = $clog2(SAMPLE_DIV);
  localparam int            CW        = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [15:0]   r_shift;
  logic          r_cs_n;
  logic          r_sclk;
  logic          r_din;
  logic          r_busy;
  logic          r_done;
  logic          r_overrun;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_bit_nxt;
  logic [15:0]   w_shift_nxt;
  logic          w_cs_n_nxt;
  logic          w_sclk_nxt;
  logic          w_din_nxt;
  logic          w_done_nxt;
  logic          w_tick;
  logic          w_cnt_last;
  logic [15:0]   w_frame;

  assign w_tick     = enable && (r_timer == TIMER_MAX);
  assign w_cnt_last = (r_cnt == CNT_MAX);
  assign w_frame    = {CTRL_BITS, wave_data, 4'b0000};

  // Sample-rate timer; a tick is the last count of each SAMPLE_DIV window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= {TW{1'b0}};
    end else if (!enable || w_tick) begin
      r_timer <= {TW{1'b0}};
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Sticky overrun: a tick that finds the serialiser busy is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (!enable) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  // Frame sequencer: next state and next value of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_cs_n_nxt  = r_cs_n;
    w_sclk_nxt  = r_sclk;
    w_din_nxt   = r_din;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_shift_nxt = w_frame;
          w_din_nxt   = w_frame[15];
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_cnt_nxt   = {CW{1'b0}};
          w_bit_nxt   = 4'd0;
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_sclk_nxt  = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!w_cnt_last) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_cnt_nxt = {CW{1'b0}};
          // Falling edge moves din on, except after the last bit so it holds into HOLD
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
            if (r_bit != 4'd15) begin
              w_shift_nxt = {r_shift[14:0], 1'b0};
              w_din_nxt   = r_shift[14];
            end else begin
              w_din_nxt = r_din;
            end
          end else if (r_bit == 4'd15) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_bit_nxt  = r_bit + 4'd1;
            w_sclk_nxt = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_cs_n_nxt  = 1'b1;
          w_din_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (w_cnt_last) begin
          w_cnt_nxt   = {CW{1'b0}};
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_din_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; busy follows the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_bit   <= 4'd0;
      r_shift <= 16'h0000;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_din   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sclk  <= w_sclk_nxt;
      r_din   <= w_din_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign dac_cs_n   = r_cs_n;
  assign dac_sclk   = r_sclk;
  assign dac_din    = r_din;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (single-frame, overrun, default rates)
// checked against a sample-tick/frame-occupancy reference model.
module tb_dac_spi_tx;

  logic       clk;
  logic       rst_n;
  logic       en    [3];
  logic [7:0] wd    [3];
  logic       cs_n  [3];
  logic       sclk  [3];
  logic       din   [3];
  logic       busy  [3];
  logic       done  [3];
  logic       ovr   [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(100), .CTRL_BITS(4'b0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .wave_data(wd[0]),
    .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_din(din[0]),
    .busy(busy[0]), .frame_done(done[0]), .overrun(ovr[0]));

  dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(50), .CTRL_BITS(4'b1001)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .wave_data(wd[1]),
    .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_din(din[1]),
    .busy(busy[1]), .frame_done(done[1]), .overrun(ovr[1]));

  dac_spi_tx u_dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en[2]), .wave_data(wd[2]),
    .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_din(din[2]),
    .busy(busy[2]), .frame_done(done[2]), .overrun(ovr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cdv(input int g);
    case (g)
      0: return 2;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int sdv(input int g);
    case (g)
      0: return 100;
      1: return 50;
      default: return 500;
    endcase
  endfunction

  function automatic logic [3:0] ctv(input int g);
    case (g)
      1: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model state
  int          en_cnt  [3];
  int          free_at [3];
  logic        e_ovr   [3];
  logic [15:0] e_frm   [3][16];
  int          e_start [3][16];
  int          e_n     [3];

  // Observed state
  logic [15:0] o_frm      [3][16];
  int          o_start    [3][16];
  int          o_len      [3][16];
  int          o_rise     [3][16];
  int          o_busy     [3][16];
  int          o_n        [3];
  int          o_nb       [3];
  int          n_done     [3];
  int          n_done_bad [3];
  int          ovr_mis    [3];
  logic [15:0] rx         [3];
  int          rises      [3];
  int          lowlen     [3];
  int          blen       [3];
  int          last_fall  [3];
  logic        p_cs       [3];
  logic        p_sclk     [3];
  logic        p_busy     [3];

  // Model: count enabled cycles; a tick every SAMPLE_DIV of them starts a frame
  // if the previous one (35*CLK_DIV busy cycles) is over, else it is an overrun.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        en_cnt[g]  = 0;
        free_at[g] = 0;
        e_ovr[g]   = 1'b0;
      end else if (!en[g]) begin
        en_cnt[g] = 0;
        e_ovr[g]  = 1'b0;
      end else begin
        en_cnt[g] = en_cnt[g] + 1;
        if (en_cnt[g] % sdv(g) == 0) begin
          if (cyc >= free_at[g]) begin
            if (e_n[g] < 16) begin
              e_frm[g][e_n[g]]   = {ctv(g), wd[g], 4'b0000};
              e_start[g][e_n[g]] = cyc + 1;
              e_n[g]             = e_n[g] + 1;
            end
            free_at[g] = cyc + 35 * cdv(g) + 1;
          end else begin
            e_ovr[g] = 1'b1;
          end
        end
      end
    end
    cyc = cyc + 1;
  end

  // Monitor: decode the SPI lines as a DAC would and measure frame timing
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        rx[g] = 16'h0000; rises[g] = 0; lowlen[g] = 0; blen[g] = 0;
      end else begin
        if (!cs_n[g] && sclk[g] && !p_sclk[g]) begin
          rx[g]    = {rx[g][14:0], din[g]};
          rises[g] = rises[g] + 1;
        end
        if (!cs_n[g]) lowlen[g] = lowlen[g] + 1;
        if (busy[g]) blen[g] = blen[g] + 1;
        if (p_cs[g] && !cs_n[g]) last_fall[g] = cyc;
        if (!p_cs[g] && cs_n[g]) begin
          if (o_n[g] < 16) begin
            o_frm[g][o_n[g]]   = rx[g];
            o_start[g][o_n[g]] = last_fall[g];
            o_len[g][o_n[g]]   = lowlen[g];
            o_rise[g][o_n[g]]  = rises[g];
            o_n[g]             = o_n[g] + 1;
          end
          rx[g] = 16'h0000; rises[g] = 0; lowlen[g] = 0;
        end
        if (p_busy[g] && !busy[g]) begin
          if (o_nb[g] < 16) begin
            o_busy[g][o_nb[g]] = blen[g];
            o_nb[g]            = o_nb[g] + 1;
          end
          blen[g] = 0;
        end
        if (done[g]) begin
          n_done[g] = n_done[g] + 1;
          if (!(!p_cs[g] && cs_n[g])) n_done_bad[g] = n_done_bad[g] + 1;
        end
        if (ovr[g] !== e_ovr[g]) ovr_mis[g] = ovr_mis[g] + 1;
      end
      p_cs[g]   = cs_n[g];
      p_sclk[g] = sclk[g];
      p_busy[g] = busy[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic clear_all();
    for (int g = 0; g < 3; g++) begin
      e_n[g] = 0; o_n[g] = 0; o_nb[g] = 0;
      n_done[g] = 0; n_done_bad[g] = 0; ovr_mis[g] = 0;
    end
  endtask

  task automatic check_inst(input int g, input string nm);
    chk({nm, "_frames"}, o_n[g], e_n[g]);
    chk({nm, "_busy_runs"}, o_nb[g], e_n[g]);
    chk({nm, "_done_count"}, n_done[g], e_n[g]);
    chk({nm, "_done_align"}, n_done_bad[g], 0);
    chk({nm, "_ovr_track"}, ovr_mis[g], 0);
    for (int k = 0; k < e_n[g] && k < o_n[g]; k++) begin
      chk($sformatf("%s_word%0d", nm, k), o_frm[g][k], e_frm[g][k]);
      chk($sformatf("%s_start%0d", nm, k), o_start[g][k], e_start[g][k]);
      chk($sformatf("%s_cs_low%0d", nm, k), o_len[g][k], 34 * cdv(g));
      chk($sformatf("%s_rises%0d", nm, k), o_rise[g][k], 16);
    end
    for (int k = 0; k < o_nb[g]; k++) begin
      chk($sformatf("%s_busy_len%0d", nm, k), o_busy[g][k], 35 * cdv(g));
    end
    e_n[g] = 0; o_n[g] = 0; o_nb[g] = 0;
    n_done[g] = 0; n_done_bad[g] = 0; ovr_mis[g] = 0;
  endtask

  int c_en;
  int c_b;
  int c_q;

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      en[g] = 1'b0; wd[g] = 8'h00;
    end
    clear_all();
    step(3);
    chk("rst_cs_n", cs_n[0], 1'b1);
    chk("rst_sclk", sclk[0], 1'b0);
    chk("rst_din", din[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_overrun", ovr[0], 1'b0);

    // Start a frame, then hit reset in the middle of SHIFT (bit 4 of 0x0A50 is 1)
    rst_n = 1'b1;
    wd[0] = 8'hA5;
    c_en  = cyc;
    en[0] = 1'b1;
    step(118);
    chk("mid_cs_n", cs_n[0], 1'b0);
    chk("mid_sclk", sclk[0], 1'b1);
    chk("mid_din", din[0], 1'b1);
    chk("mid_busy", busy[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_cs_n", cs_n[0], 1'b1);
    chk("async_sclk", sclk[0], 1'b0);
    chk("async_din", din[0], 1'b0);
    chk("async_busy", busy[0], 1'b0);
    step(3);
    chk("first_fall_latency", last_fall[0] - c_en, 100);
    chk("no_partial_frame", o_n[0], 0);
    clear_all();

    // After release a full fresh count is needed before the next frame
    rst_n = 1'b1;
    c_en  = cyc;
    step(99);
    chk("no_early_frame", cs_n[0], 1'b1);
    step(1);
    chk("fresh_fall", cs_n[0], 1'b0);
    chk("fresh_busy", busy[0], 1'b1);
    step(79);
    chk("single_count", o_n[0], 1);
    chk("single_word", o_frm[0][0], 16'h0A50);
    chk("single_cs_low", o_len[0][0], 68);
    chk("single_done", n_done[0], 1);

    // Random data every cycle on A, overrun scenario on B
    c_b   = cyc;
    en[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 99)  chk("b_ovr_before", ovr[1], 1'b0);
      if (i == 100) chk("b_ovr_second_tick", ovr[1], 1'b1);
      if (i == 160) en[1] = 1'b0;
      if (i == 162) chk("b_ovr_cleared", ovr[1], 1'b0);
      if (i == 162) chk("b_inflight_busy", busy[1], 1'b1);
      wd[0] = 8'($urandom);
      wd[1] = 8'($urandom);
      step(1);
    end
    en[0] = 1'b0;
    step(100);
    chk("b_frame_total", o_n[1], 2);
    check_inst(0, "a_rand");
    check_inst(1, "b_ovr");

    // Capture point and enable dropped mid-frame
    wd[0] = 8'h80;
    en[0] = 1'b1;
    step(120);
    wd[0] = 8'hFF;
    step(100);
    chk("a_busy_at_disable", busy[0], 1'b1);
    en[0] = 1'b0;
    step(300);
    chk("cap_count", o_n[0], 2);
    chk("cap_first", o_frm[0][0], 16'h0800);
    chk("cap_second", o_frm[0][1], 16'h0FF0);
    chk("cap_idle_cs_n", cs_n[0], 1'b1);
    check_inst(0, "a_cap");

    // Square wave on the default-parameter instance
    c_q   = cyc;
    wd[2] = 8'd255;
    en[2] = 1'b1;
    step(600);
    wd[2] = 8'd128;
    step(500);
    wd[2] = 8'd255;
    step(500);
    wd[2] = 8'd128;
    step(500);
    chk("sq_overrun", ovr[2], 1'b0);
    en[2] = 1'b0;
    step(200);
    chk("sq_count", o_n[2], 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sq_data%0d", k), o_frm[2][k][11:4], (k % 2 == 0) ? 8'hFF : 8'h80);
    end
    chk("sq_first_fall", o_start[2][0] - c_q, 500);
    check_inst(2, "c_sq");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
